fifo_burst_reader: RTL and testbench
====================================

# fifo_burst_reader

Read-side master for the synchronous FIFO: on a start pulse it drains exactly `burst_len` words from the FIFO's read port and delivers them on a valid/ready stream. It sits between the FIFO's read interface and a downstream consumer, absorbing the FIFO's one-cycle read latency with a 2-entry skid buffer. It never issues a read while the FIFO reports empty, and flags any FIFO underflow as a sticky error.

## Interface
- FIFO_WIDTH, 16, data word width (matches FIFO)
- FIFO_DEPTH, 8, FIFO depth (informational; bounds nothing here)
- LEN_WIDTH, 8, width of burst length and counters

- clk  in  1  single clock, all logic on posedge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  burst request; accepted only in IDLE, ignored otherwise
- burst_len  in  LEN_WIDTH  words to transfer, sampled with accepted start
- busy  out  1  high from cycle after accepted start until done pulse inclusive
- done  out  1  one-cycle pulse after last word handed off
- fifo_rd_en  out  1  FIFO read enable
- fifo_data_out  in  FIFO_WIDTH  FIFO read data, valid the cycle after a granted read
- fifo_empty  in  1  FIFO empty flag
- fifo_underflow  in  1  FIFO underflow flag
- m_data  out  FIFO_WIDTH  stream data (skid head)
- m_valid  out  1  stream valid
- m_ready  in  1  stream ready
- err_underflow  out  1  sticky; set on fifo_underflow while busy, cleared by accepted start

## Operation
- States: IDLE, ACTIVE, DONE.
- IDLE: start=1 loads issue_left and deliver_left from burst_len, clears err_underflow. burst_len=0 goes to DONE; otherwise goes to ACTIVE.
- ACTIVE: fifo_rd_en = (issue_left!=0) && !fifo_empty && (occ + inflight - pop) < 2.
  - occ = skid occupancy (0..2).
  - inflight = registered copy of last cycle's fifo_rd_en.
  - pop = m_valid && m_ready.
  - fifo_rd_en is combinational from registered state plus fifo_empty and m_ready.
- Each fifo_rd_en decrements issue_left. When inflight=1, fifo_data_out is written into the skid tail on that edge.
- m_valid = (occ!=0); m_data = skid head. Each pop decrements deliver_left. The pop that takes deliver_left 1→0 moves the FSM to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Overflow of the skid is impossible by construction. An inflight write into a full skid is a design error; the bench checks for it.
- fifo_underflow sampled high while state≠IDLE sets err_underflow. The transfer otherwise continues.
- Counters never wrap: decrement only when nonzero.

## Timing
- Reset values: state=IDLE, busy=0, done=0, fifo_rd_en=0, m_valid=0, m_data=0, err_underflow=0, all counters 0, occ=0, inflight=0.
- start sampled at edge E0 → busy=1 and fifo_rd_en possible in cycle 1 → data captured at E2 → m_valid=1 in cycle 3. Start-to-first-valid latency is 3 cycles.
- Throughput: 1 word/cycle sustained while FIFO non-empty and m_ready=1.
- m_valid/m_data hold stable until accepted; no combinational path from m_ready to m_valid.
- fifo_empty asserted mid-burst: reads stall, stream drains buffered words, resumes when non-empty.
- start while busy: ignored, no effect on counters or err.
- rst_n low mid-burst: immediate return to reset values. In-flight data is discarded and no done pulse is issued.

## Structure
- Package fifo_rd_pkg: state enum (IDLE, ACTIVE, DONE) and the skid depth constant SKID_DEPTH=2.
- Sub-module fifo_rd_skid: 2-entry register buffer with push/pop, occ output, head data. The top holds FSM, counters and read-issue logic.

## Test plan
- Reset with rst_n=0 mid-burst: all outputs at reset values within the same cycle; after release, start with burst_len=3 works normally.
- FIFO preloaded 0x11,0x22,0x33,0x44, m_ready=1, start with burst_len=4: m_valid cycles 3–6 with those words in order, done pulse in cycle 7, fifo_rd_en high exactly 4 cycles.
- Same burst with m_ready toggling 1,0,0,1,...: no word lost or duplicated, occ+inflight never exceeds 2, m_data stable while stalled.
- FIFO holds 2 words, burst_len=5; remaining 3 words written 10 cycles later: rd_en never high while fifo_empty=1, all 5 delivered, then done.
- burst_len=0: done pulse one cycle after start, fifo_rd_en never asserted, m_valid stays 0.
- Force fifo_underflow=1 for one cycle while busy: err_underflow=1 and sticky through done; next accepted start clears it.

Source files
------------

// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO burst reader.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam int SKID_DEPTH = 2;
  localparam int OCC_W      = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/fifo_burst_reader_if.sv
// FIFO read port plus the outgoing valid/ready stream, seen from the reader (master) side.
interface fifo_burst_reader_if #(
  parameter int FIFO_WIDTH = 16
);
  logic                  fifo_rd_en;
  logic [FIFO_WIDTH-1:0] fifo_data_out;
  logic                  fifo_empty;
  logic                  fifo_underflow;
  logic [FIFO_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;

  modport master (
    output fifo_rd_en, m_data, m_valid,
    input  fifo_data_out, fifo_empty, fifo_underflow, m_ready
  );

  modport slave (
    input  fifo_rd_en, m_data, m_valid,
    output fifo_data_out, fifo_empty, fifo_underflow, m_ready
  );
endinterface

// File: rtl/fifo_rd_skid.sv
// Two-entry register skid buffer; head is always the oldest word.
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [OCC_W-1:0] occ_o,
  output logic [WIDTH-1:0] head_o
);

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [OCC_W-1:0] occ_q, occ_d;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    unique case ({push_i, pop_i})
      2'b10: begin
        if (occ_q == '0) head_d = data_i;
        else             tail_d = data_i;
        if (occ_q != OCC_W'(SKID_DEPTH)) occ_d = occ_q + 1'b1;
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 1'b1;
      end
      2'b11: begin
        // Occupancy is unchanged; the incoming word lands behind whatever remains.
        if (occ_q == OCC_W'(1)) begin
          head_d = data_i;
        end else begin
          head_d = tail_q;
          tail_d = data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  assign occ_o  = occ_q;
  assign head_o = head_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains burst_len words from a FIFO read port onto a valid/ready stream,
// hiding the FIFO's one-cycle read latency behind a 2-entry skid buffer.
module fifo_burst_reader
  import fifo_rd_pkg::*;
#(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] burst_len,
  output logic                 busy,
  output logic                 done,
  output logic                 err_underflow,
  fifo_burst_reader_if.master  bus
);

  if (FIFO_DEPTH < 1) begin : g_depth_chk
    $error("fifo_burst_reader: FIFO_DEPTH must be positive");
  end

  state_e               state_q, state_d;
  logic [LEN_WIDTH-1:0] issue_q, issue_d;
  logic [LEN_WIDTH-1:0] deliver_q, deliver_d;
  logic                 inflight_q;
  logic                 err_q, err_d;

  logic [OCC_W-1:0]      occ;
  logic [FIFO_WIDTH-1:0] head;
  logic                  pop;
  logic                  rd_en;
  logic [2:0]            pending;

  // Words already committed to the skid next cycle if nothing more is read.
  assign pop     = (occ != '0) && bus.m_ready;
  assign pending = 3'(occ) + 3'(inflight_q) - 3'(pop);
  assign rd_en   = (state_q == ACTIVE) && (issue_q != '0) && !bus.fifo_empty
                   && (pending < 3'(SKID_DEPTH));

  fifo_rd_skid #(.WIDTH(FIFO_WIDTH)) u_skid (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (inflight_q),
    .data_i (bus.fifo_data_out),
    .pop_i  (pop),
    .occ_o  (occ),
    .head_o (head)
  );

  always_comb begin
    state_d   = state_q;
    issue_d   = issue_q;
    deliver_d = deliver_q;
    err_d     = err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          issue_d   = burst_len;
          deliver_d = burst_len;
          err_d     = 1'b0;
          state_d   = (burst_len == '0) ? DONE : ACTIVE;
        end
      end
      ACTIVE: begin
        if (rd_en && issue_q != '0) issue_d = issue_q - 1'b1;
        if (pop && deliver_q != '0) begin
          deliver_d = deliver_q - 1'b1;
          if (deliver_q == LEN_WIDTH'(1)) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && bus.fifo_underflow) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      issue_q    <= '0;
      deliver_q  <= '0;
      inflight_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      issue_q    <= issue_d;
      deliver_q  <= deliver_d;
      inflight_q <= rd_en;
      err_q      <= err_d;
    end
  end

  assign busy           = (state_q != IDLE);
  assign done           = (state_q == DONE);
  assign err_underflow  = err_q;
  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = (occ != '0);
  assign bus.m_data     = head;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: behavioural FIFO on the read side, scoreboard on the stream side.
module tb_fifo_burst_reader;

  localparam int W  = 16;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [LW-1:0] burst_len;
  logic          busy, done, err;

  fifo_burst_reader_if #(.FIFO_WIDTH(W)) bus ();

  fifo_burst_reader #(.FIFO_WIDTH(W), .FIFO_DEPTH(8), .LEN_WIDTH(LW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .burst_len     (burst_len),
    .busy          (busy),
    .done          (done),
    .err_underflow (err),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int pops   = 0;
  int viol_empty = 0, viol_occ = 0, viol_stab = 0;
  logic         stall_q = 1'b0;
  logic [W-1:0] stall_data = '0;
  logic [W-1:0] mon_e;
  logic [W-1:0] fq[$];
  logic [W-1:0] exp_q[$];

  // Behavioural FIFO: data appears the cycle after a granted read.
  assign bus.fifo_empty = (wr_cnt == rd_cnt);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.fifo_rd_en && fq.size() != 0) begin
      bus.fifo_data_out <= fq.pop_front();
      rd_cnt <= rd_cnt + 1;
    end
  end

  // Stream monitor: scoreboard pop on every handshake, plus protocol invariants.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.fifo_rd_en && bus.fifo_empty) viol_empty++;
      if (int'(dut.u_skid.occ_o) + int'(dut.inflight_q) > 2) viol_occ++;
      if (stall_q && (!bus.m_valid || bus.m_data !== stall_data)) viol_stab++;
      if (bus.m_valid && bus.m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_extra: got word %h, required none", bus.m_data);
        end else begin
          mon_e = exp_q.pop_front();
          if (bus.m_data !== mon_e) begin
            errors++;
            $display("FAIL sb_data: got %h, required %h", bus.m_data, mon_e);
          end
        end
        pops++;
      end
      stall_q    = bus.m_valid && !bus.m_ready;
      stall_data = bus.m_data;
    end else begin
      stall_q = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fifo_write(input logic [W-1:0] w);
    fq.push_back(w);
    exp_q.push_back(w);
    wr_cnt = wr_cnt + 1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, bus.fifo_rd_en, bus.m_valid, err, bus.m_data} !== '0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b rd=%b v=%b err=%b d=%h, required all 0",
               busy, done, bus.fifo_rd_en, bus.m_valid, err, bus.m_data);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int s, rel, first_v, last_v, nv, nd, done_c, nrd, p0;
    first_v = -1; last_v = -1; nv = 0; nd = 0; done_c = -1; nrd = 0;
    p0 = pops;
    fifo_write(16'h0011); fifo_write(16'h0022); fifo_write(16'h0033); fifo_write(16'h0044);
    bus.m_ready = 1'b1;
    burst_len = 8'd4;
    start = 1'b1;
    s = cyc;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      rel = cyc - s;
      if (bus.m_valid) begin
        if (first_v < 0) first_v = rel;
        last_v = rel;
        nv++;
      end
      if (done) begin nd++; done_c = rel; end
      if (bus.fifo_rd_en) nrd++;
    end
    checks++; if (first_v !== 3) begin errors++; $display("FAIL basic_first_valid: got %0d, required 3", first_v); end
    checks++; if (last_v !== 6)  begin errors++; $display("FAIL basic_last_valid: got %0d, required 6", last_v); end
    checks++; if (nv !== 4)      begin errors++; $display("FAIL basic_valid_cycles: got %0d, required 4", nv); end
    checks++; if (done_c !== 7 || nd !== 1) begin errors++; $display("FAIL basic_done: got cycle %0d count %0d, required cycle 7 count 1", done_c, nd); end
    checks++; if (nrd !== 4)     begin errors++; $display("FAIL basic_rd_en: got %0d cycles, required 4", nrd); end
    checks++; if (pops - p0 !== 4 || exp_q.size() !== 0) begin errors++; $display("FAIL basic_delivered: got %0d left %0d, required 4 left 0", pops - p0, exp_q.size()); end
    tick();
  endtask

  task automatic test_backpressure();
    int p0, vo, vs, nstall;
    logic seen;
    p0 = pops; vo = viol_occ; vs = viol_stab; nstall = 0; seen = 1'b0;
    fifo_write(16'h0055); fifo_write(16'h0066); fifo_write(16'h0077); fifo_write(16'h0088);
    burst_len = 8'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      bus.m_ready = (i % 3 == 0);
      @(negedge clk);
      if (bus.m_valid && !bus.m_ready) nstall++;
      if (done) seen = 1'b1;
      tick();
    end
    bus.m_ready = 1'b1;
    checks++; if (!seen) begin errors++; $display("FAIL bp_done: got no done in 60 cycles, required done"); end
    checks++; if (pops - p0 !== 4 || exp_q.size() !== 0) begin errors++; $display("FAIL bp_delivered: got %0d left %0d, required 4 left 0", pops - p0, exp_q.size()); end
    checks++; if (viol_occ - vo !== 0) begin errors++; $display("FAIL bp_occ_bound: got %0d violations, required 0", viol_occ - vo); end
    checks++; if (viol_stab - vs !== 0 || nstall == 0) begin errors++; $display("FAIL bp_stable: got %0d violations over %0d stalls, required 0 over >0", viol_stab - vs, nstall); end
  endtask

  task automatic test_empty_stall();
    int p0, ve, nempty;
    logic seen;
    p0 = pops; ve = viol_empty; nempty = 0; seen = 1'b0;
    fifo_write(16'h00C1); fifo_write(16'h00C2);
    bus.m_ready = 1'b1;
    burst_len = 8'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 60 && !seen; i++) begin
      if (i == 10) begin fifo_write(16'h00C3); fifo_write(16'h00C4); fifo_write(16'h00C5); end
      @(negedge clk);
      if (busy && bus.fifo_empty) nempty++;
      if (done) seen = 1'b1;
      tick();
    end
    checks++; if (!seen) begin errors++; $display("FAIL empty_done: got no done in 60 cycles, required done"); end
    checks++; if (pops - p0 !== 5 || exp_q.size() !== 0) begin errors++; $display("FAIL empty_delivered: got %0d left %0d, required 5 left 0", pops - p0, exp_q.size()); end
    checks++; if (viol_empty - ve !== 0 || nempty == 0) begin errors++; $display("FAIL empty_rd_guard: got %0d reads-while-empty over %0d empty cycles, required 0 over >0", viol_empty - ve, nempty); end
  endtask

  task automatic test_zero();
    int s, rel, done_c, nd, nrd, nv;
    done_c = -1; nd = 0; nrd = 0; nv = 0;
    burst_len = 8'd0;
    start = 1'b1;
    s = cyc;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      rel = cyc - s;
      if (done) begin nd++; done_c = rel; end
      if (bus.fifo_rd_en) nrd++;
      if (bus.m_valid) nv++;
    end
    checks++; if (done_c !== 1 || nd !== 1) begin errors++; $display("FAIL zero_done: got cycle %0d count %0d, required cycle 1 count 1", done_c, nd); end
    checks++; if (nrd !== 0 || nv !== 0) begin errors++; $display("FAIL zero_quiet: got rd=%0d valid=%0d, required 0 0", nrd, nv); end
    tick();
  endtask

  task automatic test_underflow_sticky();
    int p0;
    logic seen;
    p0 = pops; seen = 1'b0;
    fifo_write(16'h00D1); fifo_write(16'h00D2); fifo_write(16'h00D3);
    bus.m_ready = 1'b0;
    burst_len = 8'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 40 && !seen; i++) begin
      bus.fifo_underflow = (i == 2);
      start = (i == 4);
      burst_len = (i == 4) ? 8'd1 : 8'd3;
      bus.m_ready = (i >= 6);
      @(negedge clk);
      if (i == 4) begin
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL uf_set: got err=%b, required 1", err); end
      end
      if (done) begin
        seen = 1'b1;
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL uf_sticky_done: got err=%b, required 1", err); end
      end
      tick();
    end
    start = 1'b0;
    checks++; if (!seen || pops - p0 !== 3 || exp_q.size() !== 0) begin errors++; $display("FAIL uf_transfer: got done=%b words=%0d left %0d, required 1 3 0", seen, pops - p0, exp_q.size()); end
    checks++; if (err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL uf_idle_hold: got err=%b busy=%b, required 1 0", err, busy); end
    burst_len = 8'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    checks++; if (err !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL uf_clear: got err=%b done=%b, required 0 1", err, done); end
    tick();
  endtask

  task automatic test_reset_mid_burst();
    int p0;
    logic seen;
    seen = 1'b0;
    fifo_write(16'h00A1); fifo_write(16'h00A2); fifo_write(16'h00A3);
    bus.m_ready = 1'b0;
    burst_len = 8'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    checks++; if (bus.m_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL rst_pre: got valid=%b busy=%b, required 1 1", bus.m_valid, busy); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, bus.fifo_rd_en, bus.m_valid, err, bus.m_data, dut.u_skid.occ_o} !== '0) begin
      errors++;
      $display("FAIL rst_mid: got busy=%b done=%b rd=%b v=%b err=%b d=%h occ=%0d, required all 0",
               busy, done, bus.fifo_rd_en, bus.m_valid, err, bus.m_data, dut.u_skid.occ_o);
    end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_no_done: got done=%b, required 0", done); end
    fq.delete();
    exp_q.delete();
    wr_cnt = rd_cnt;
    rst_n = 1'b1;
    tick();
    p0 = pops;
    fifo_write(16'h00B1); fifo_write(16'h00B2); fifo_write(16'h00B3);
    bus.m_ready = 1'b1;
    burst_len = 8'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    checks++; if (!seen || pops - p0 !== 3 || exp_q.size() !== 0) begin errors++; $display("FAIL rst_after: got done=%b words=%0d left %0d, required 1 3 0", seen, pops - p0, exp_q.size()); end
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    burst_len = '0;
    bus.m_ready = 1'b0;
    bus.fifo_underflow = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_empty_stall();
    test_zero();
    test_underflow_sticky();
    test_reset_mid_burst();
    checks++;
    if (viol_occ !== 0 || viol_stab !== 0 || viol_empty !== 0) begin
      errors++;
      $display("FAIL invariants: got occ=%0d stab=%0d empty=%0d violations, required 0 0 0", viol_occ, viol_stab, viol_empty);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion by 200000, required completion");
    $fatal(1, "timeout");
  end

endmodule
